vec_scale_pipe: RTL and testbench
=================================

// Module: vec_scale_pipe
// PURPOSE
//  Parametrised, fully pipelined fixed-point vector scaler for the fifo_math library.
//  - Multiplies each of CHANNELS signed lanes x[i] by a shared scalar a in Q(Q_BITS) format.
//  - Throughput: one vector per clock.
//  - Selectable rounding and saturate/wrap overflow handling; sticky overflow flag.
//  - Sits between an upstream FWFT FIFO (empty/rd_en) and a downstream FIFO (full/wr_en).
// PARAMETERS
//  DATA_WIDTH  32  lane and scalar width, signed two's complement
//  Q_BITS      16  fractional bits; must satisfy 1 <= Q_BITS < DATA_WIDTH
//  CHANNELS    3   number of vector lanes
//  ROUND_MODE  0   0 = truncate (arithmetic shift, toward -inf); 1 = round-half-up
//  SATURATE    1   1 = clamp to [MIN, MAX]; 0 = wrap (keep low DATA_WIDTH bits)
// PORTS
//  clock       in   1                      single clock, rising edge
//  reset_n     in   1                      asynchronous, active-low reset
//  x           in   DATA_WIDTH x CHANNELS  input vector, signed, unpacked [CHANNELS-1:0]
//  a           in   DATA_WIDTH             scale factor, signed
//  in_empty    in   1                      upstream FIFO empty
//  in_rd_en    out  1                      pop upstream; x and a sampled in this same cycle
//  out         out  DATA_WIDTH x CHANNELS  result vector, valid while out_wr_en = 1
//  out_full    in   1                      downstream FIFO full
//  out_wr_en   out  1                      push result downstream
//  ovf_clr     in   1                      clears ovf_sticky
//  ovf_sticky  out  1                      set when any lane result overflowed DATA_WIDTH
// BEHAVIOUR
//  Clock and reset: one clock; reset is asynchronous and active-low.
//  Reset state: s1_valid = s2_valid = 0; all data registers = 0; ovf_sticky = 0.
//   Consequently in_rd_en = 0 and out_wr_en = 0 during and after reset.
//  Pipeline (2 registered stages, per lane):
//   S1: p[i] = x[i] * a, full 2*DATA_WIDTH signed product.
//   S2: apply rounding (ROUND_MODE = 1 adds 1 << (Q_BITS-1) to p before the shift);
//       r = p >>> Q_BITS; then saturate or wrap to DATA_WIDTH bits.
//  Overflow: r outside [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
//   SATURATE = 1: clamp to the nearest limit. SATURATE = 0: keep the low bits.
//   Either mode: raises the lane overflow bit.
//  Flow control:
//   advance   = !(s2_valid && out_full)
//   in_rd_en  = !in_empty && advance
//   out_wr_en = s2_valid && !out_full
//   On advance: S2 <= S1 (incl. valid) and S1 <= (input, in_rd_en).
//   When advance = 0: both stages hold unchanged; no bubble is inserted or lost.
//  Latency: pop in cycle t -> out_wr_en in cycle t+2 when out_full = 0.
//   Sustained 1 vector/cycle. Output order equals input order.
//  ovf_sticky: set in the cycle a flagged vector is written (out_wr_en = 1).
//   ovf_clr clears it. If set and clear coincide in the same cycle, set wins.
//  Boundaries:
//   in_empty with an empty pipe: outputs idle.
//   out_full with a full pipe: in_rd_en = 0 until space frees.
//   Removing out_full: drain resumes in the same cycle.
//   reset_n asserted mid-stream: in-flight vectors are discarded; no partial write.
//  Results are combinational-free: out comes directly from S2 registers.
// STRUCTURE
//  fifo_math_pkg:
//   - round_mode_e {RND_TRUNC, RND_HALF_UP}
//   - function sat_to_width()
//   - localparams for MIN/MAX derivation
//  Sub-module fixed_mul_q: one lane.
//   - S1 multiply register and S2 round/shift/saturate register.
//   - Shared enable = advance; ovf output per lane.
//   - Instantiated CHANNELS times by a generate loop.
//  Top: valid/advance control, ovf OR-reduce, sticky register.
//  Downstream FIFO instantiated by the parent, not here.
// TESTING
//  Defaults throughout; all values are hex.
//  1. x = (10000, FFFF0000, 28000), a = 20000, out_full = 0
//     -> out = (20000, FFFE0000, 50000), out_wr_en exactly 2 cycles after in_rd_en.
//  2. x0 = 7FFF0000, a = 20000
//     - SATURATE = 1 -> 7FFFFFFF, ovf_sticky = 1.
//     - SATURATE = 0 -> FFFE0000, ovf_sticky = 1.
//     - ovf_clr pulse -> 0.
//  3. Rounding, x0 = 1, a = 8000 -> ROUND_MODE 0 gives 0; ROUND_MODE 1 gives 1.
//     x0 = FFFFFFFF, a = 8000 -> ROUND_MODE 0 gives FFFFFFFF; ROUND_MODE 1 gives 0.
//  4. Stream 8 distinct vectors back-to-back; hold out_full = 1 for 5 cycles mid-stream.
//     -> exactly 8 writes, in order, no duplicates.
//     -> in_rd_en = 0 while the pipe is full and blocked.
//  5. Same cycle: ovf_clr = 1 and an overflowing vector is written -> ovf_sticky = 1.
//  6. Assert reset_n = 0 with 2 vectors in flight
//     -> out_wr_en drops immediately, nothing is written.
//     -> after release, the next input is processed normally.

Source files
------------

// File: rtl/vec_scale_pipe_pkg.sv
// Shared types and saturation helpers for the vector scaler.
package vec_scale_pipe_pkg;

  typedef enum logic {
    RND_TRUNC   = 1'b0,
    RND_HALF_UP = 1'b1
  } round_mode_e;

  // Working width for the generic saturation helpers; the lane product
  // (2*DATA_WIDTH+1 bits) must fit inside it.
  localparam int MAX_W = 128;

  typedef logic signed [MAX_W-1:0] wide_t;

  // Largest positive value of a w-bit signed number, sign-extended to MAX_W.
  function automatic wide_t lim_max(input int w);
    return wide_t'((MAX_W'(1) << (w - 1)) - MAX_W'(1));
  endfunction

  // Most negative value of a w-bit signed number, sign-extended to MAX_W.
  function automatic wide_t lim_min(input int w);
    return ~lim_max(w);
  endfunction

  // True when r is representable as a w-bit signed value.
  function automatic logic fits_width(input wide_t r, input int w);
    wide_t hi;
    hi = r >>> (w - 1);
    return (hi == '0) || (hi == '1);
  endfunction

  // Clamp r to the w-bit signed range when sat is set; otherwise pass it
  // through so the caller keeps only the low bits (wrap).
  function automatic wide_t sat_to_width(input wide_t r, input int w, input logic sat);
    if (sat && !fits_width(r, w))
      return r[MAX_W-1] ? lim_min(w) : lim_max(w);
    return r;
  endfunction

endpackage

// File: rtl/vec_scale_pipe_if.sv
// FIFO-side bus of the scaler: FWFT pop side and push side.
interface vec_scale_pipe_if #(
  parameter int DATA_WIDTH = 32,
  parameter int CHANNELS   = 3
);
  logic [CHANNELS-1:0][DATA_WIDTH-1:0] x;
  logic [DATA_WIDTH-1:0]               a;
  logic                                in_empty;
  logic                                in_rd_en;
  logic [CHANNELS-1:0][DATA_WIDTH-1:0] out;
  logic                                out_full;
  logic                                out_wr_en;

  // Environment side: upstream FIFO data/status and downstream full.
  modport master (
    output x, a, in_empty, out_full,
    input  in_rd_en, out, out_wr_en
  );

  // Scaler side.
  modport slave (
    input  x, a, in_empty, out_full,
    output in_rd_en, out, out_wr_en
  );
endinterface

// File: rtl/vec_scale_pipe_fixed_mul_q.sv
// One lane: S1 full-width multiply, S2 round / shift / saturate-or-wrap.
module vec_scale_pipe_fixed_mul_q
  import vec_scale_pipe_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int Q_BITS     = 16,
  parameter int ROUND_MODE = 0,
  parameter int SATURATE   = 1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] x_i,
  input  logic [DATA_WIDTH-1:0] a_i,
  output logic [DATA_WIDTH-1:0] y_o,
  output logic                  ovf_o
);

  localparam int PW = 2 * DATA_WIDTH + 1;  // product plus headroom for the rounding add
  localparam logic [PW-1:0] RND_K =
    (ROUND_MODE == int'(RND_HALF_UP)) ? (PW'(1) << (Q_BITS - 1)) : '0;

  if (Q_BITS < 1 || Q_BITS >= DATA_WIDTH) begin : g_bad_q
    $error("Q_BITS must satisfy 1 <= Q_BITS < DATA_WIDTH");
  end
  if (PW > MAX_W) begin : g_bad_w
    $error("DATA_WIDTH too large for the saturation helpers");
  end

  logic signed [2*DATA_WIDTH-1:0] p_d, p_q;
  logic signed [PW-1:0]           sum, r;
  wide_t                          r_ext;
  logic [DATA_WIDTH-1:0]          y_d, y_q;
  logic                           ovf_d, ovf_q;

  // S1: exact signed product, operands sign-extended so nothing is lost.
  always_comb begin
    p_d = p_q;
    if (en)
      p_d = $signed({{DATA_WIDTH{x_i[DATA_WIDTH-1]}}, x_i}) *
            $signed({{DATA_WIDTH{a_i[DATA_WIDTH-1]}}, a_i});
  end

  // S2: optional half-up bias, arithmetic shift, then clamp or wrap.
  always_comb begin
    sum   = $signed({p_q[2*DATA_WIDTH-1], p_q}) + $signed(RND_K);
    r     = sum >>> Q_BITS;
    r_ext = {{(MAX_W-PW){r[PW-1]}}, r};
    y_d   = y_q;
    ovf_d = ovf_q;
    if (en) begin
      y_d   = DATA_WIDTH'(sat_to_width(r_ext, DATA_WIDTH, SATURATE != 0));
      ovf_d = !fits_width(r_ext, DATA_WIDTH);
    end
  end

  // Stage registers; all cleared on reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      p_q   <= '0;
      y_q   <= '0;
      ovf_q <= 1'b0;
    end else begin
      p_q   <= p_d;
      y_q   <= y_d;
      ovf_q <= ovf_d;
    end
  end

  assign y_o   = y_q;
  assign ovf_o = ovf_q;

endmodule

// File: rtl/vec_scale_pipe.sv
// Two-stage fixed-point vector scaler between an FWFT FIFO and a push FIFO.
module vec_scale_pipe
  import vec_scale_pipe_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int Q_BITS     = 16,
  parameter int CHANNELS   = 3,
  parameter int ROUND_MODE = 0,
  parameter int SATURATE   = 1
) (
  input  logic                clock,
  input  logic                reset_n,
  vec_scale_pipe_if.slave     bus,
  input  logic                ovf_clr,
  output logic                ovf_sticky
);

  logic                s1_valid_d, s1_valid_q;
  logic                s2_valid_d, s2_valid_q;
  logic                run_d, run_q;
  logic                ovf_sticky_d, ovf_sticky_q;
  logic                advance;
  logic [CHANNELS-1:0] lane_ovf;

  // Whole pipe moves together; it only stalls when the output stage is
  // occupied and the downstream FIFO refuses it. run_q keeps the pop request
  // low while reset is held and for the first edge after release.
  always_comb begin
    advance       = !(s2_valid_q && bus.out_full);
    bus.in_rd_en  = run_q && !bus.in_empty && advance;
    bus.out_wr_en = s2_valid_q && !bus.out_full;
  end

  // Valid shift and sticky overflow; a new overflow beats a simultaneous clear.
  always_comb begin
    run_d        = 1'b1;
    s1_valid_d   = s1_valid_q;
    s2_valid_d   = s2_valid_q;
    ovf_sticky_d = ovf_sticky_q;
    if (advance) begin
      s2_valid_d = s1_valid_q;
      s1_valid_d = bus.in_rd_en;
    end
    if (ovf_clr)
      ovf_sticky_d = 1'b0;
    if (bus.out_wr_en && |lane_ovf)
      ovf_sticky_d = 1'b1;
  end

  // Control registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      run_q        <= 1'b0;
      s1_valid_q   <= 1'b0;
      s2_valid_q   <= 1'b0;
      ovf_sticky_q <= 1'b0;
    end else begin
      run_q        <= run_d;
      s1_valid_q   <= s1_valid_d;
      s2_valid_q   <= s2_valid_d;
      ovf_sticky_q <= ovf_sticky_d;
    end
  end

  assign ovf_sticky = ovf_sticky_q;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
    vec_scale_pipe_fixed_mul_q #(
      .DATA_WIDTH (DATA_WIDTH),
      .Q_BITS     (Q_BITS),
      .ROUND_MODE (ROUND_MODE),
      .SATURATE   (SATURATE)
    ) u_lane (
      .clock   (clock),
      .reset_n (reset_n),
      .en      (advance),
      .x_i     (bus.x[i]),
      .a_i     (bus.a),
      .y_o     (bus.out[i]),
      .ovf_o   (lane_ovf[i])
    );
  end

endmodule

// File: tb/tb_vec_scale_pipe.sv
// Scoreboard bench: default scaler (truncate, saturate) and a round/wrap
// variant receive identical stimulus; a monitor checks every write.
module tb_vec_scale_pipe;
  import vec_scale_pipe_pkg::*;

  localparam int DW = 32;
  localparam int CH = 3;
  typedef logic [CH-1:0][DW-1:0] vec_t;

  typedef struct {
    vec_t em;
    vec_t ea;
    int   pop_cyc;
    bit   chk_lat;
  } exp_t;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  logic ovf_clr = 1'b0;
  logic sticky_m, sticky_a;

  vec_scale_pipe_if #(.DATA_WIDTH(DW), .CHANNELS(CH)) m_if ();
  vec_scale_pipe_if #(.DATA_WIDTH(DW), .CHANNELS(CH)) a_if ();

  vec_scale_pipe #(.DATA_WIDTH(DW), .Q_BITS(16), .CHANNELS(CH),
                   .ROUND_MODE(0), .SATURATE(1)) u_main (
    .clock(clock), .reset_n(reset_n), .bus(m_if.slave),
    .ovf_clr(ovf_clr), .ovf_sticky(sticky_m));

  vec_scale_pipe #(.DATA_WIDTH(DW), .Q_BITS(16), .CHANNELS(CH),
                   .ROUND_MODE(1), .SATURATE(0)) u_alt (
    .clock(clock), .reset_n(reset_n), .bus(a_if.slave),
    .ovf_clr(ovf_clr), .ovf_sticky(sticky_a));

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  exp_t sb[$];
  int   n_cmp  = 0;
  int   n_bad  = 0;
  int   n_wr   = 0;
  int   n_push = 0;
  int   pops   = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %b, want %b (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic vec_t mk(input logic [DW-1:0] v0, input logic [DW-1:0] v1,
                              input logic [DW-1:0] v2);
    vec_t v;
    v[0] = v0;
    v[1] = v1;
    v[2] = v2;
    return v;
  endfunction

  task automatic set_in(input vec_t x, input logic [DW-1:0] a);
    m_if.x = x;  a_if.x = x;
    m_if.a = a;  a_if.a = a;
  endtask

  task automatic set_empty(input logic e);
    m_if.in_empty = e;
    a_if.in_empty = e;
  endtask

  task automatic set_full(input logic f);
    m_if.out_full = f;
    a_if.out_full = f;
  endtask

  // Present one vector, wait (bounded) for the pop, record the expectation.
  task automatic push(input vec_t x, input logic [DW-1:0] a, input vec_t em,
                      input vec_t ea, input bit sb_en, input bit lat);
    bit got;
    got = 1'b0;
    set_in(x, a);
    set_empty(1'b0);
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (m_if.in_rd_en) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      n_cmp++;
      n_bad++;
      $display("FAIL pop_timeout: in_rd_en never rose for x0=%h", x[0]);
    end else begin
      if (sb_en) begin
        sb.push_back('{em, ea, cyc, lat});
        n_push++;
      end
      pops++;
    end
    @(posedge clock);
    #1;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 50 && sb.size() != 0; i++) @(posedge clock);
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: %0d results still pending", sb.size());
    end
    repeat (2) @(posedge clock);
    #1;
  endtask

  // Monitor: every write must match the oldest outstanding expectation.
  always @(negedge clock) begin : mon
    exp_t e;
    if (m_if.out_wr_en) begin
      n_wr++;
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_write: out=%h", m_if.out);
      end else begin
        e = sb.pop_front();
        for (int i = 0; i < CH; i++) begin
          chk($sformatf("main_out%0d", i), m_if.out[i], e.em[i]);
          chk($sformatf("alt_out%0d", i), a_if.out[i], e.ea[i]);
        end
        chk1("alt_wr_en", a_if.out_wr_en, 1'b1);
        if (e.chk_lat) chk("latency", DW'(cyc - e.pop_cyc), 32'd2);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL global_timeout: bench did not complete");
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "timeout");
  end

  initial begin : stim
    int w0, p0;
    set_in(mk(0, 0, 0), 0);
    set_empty(1'b0);
    set_full(1'b0);

    // Reset state, with data offered upstream.
    repeat (2) @(negedge clock);
    chk1("rst_in_rd_en", m_if.in_rd_en, 1'b0);
    chk1("rst_out_wr_en", m_if.out_wr_en, 1'b0);
    chk1("rst_sticky_main", sticky_m, 1'b0);
    chk1("rst_sticky_alt", sticky_a, 1'b0);
    set_empty(1'b1);
    @(posedge clock);
    #1 reset_n = 1'b1;
    repeat (2) @(posedge clock);
    #1;

    // 1: basic scale by 2.0
    push(mk(32'h10000, 32'hFFFF0000, 32'h28000), 32'h20000,
         mk(32'h20000, 32'hFFFE0000, 32'h50000),
         mk(32'h20000, 32'hFFFE0000, 32'h50000), 1, 1);
    set_empty(1'b1);
    wait_drain();
    chk1("t1_sticky_main", sticky_m, 1'b0);

    // 2: overflow, saturate vs wrap, then clear
    push(mk(32'h7FFF0000, 0, 0), 32'h20000,
         mk(32'h7FFFFFFF, 0, 0), mk(32'hFFFE0000, 0, 0), 1, 1);
    set_empty(1'b1);
    wait_drain();
    @(negedge clock);
    chk1("t2_sticky_main", sticky_m, 1'b1);
    chk1("t2_sticky_alt", sticky_a, 1'b1);
    @(posedge clock);
    #1 ovf_clr = 1'b1;
    @(posedge clock);
    #1 ovf_clr = 1'b0;
    @(negedge clock);
    chk1("t2_clr_main", sticky_m, 1'b0);
    chk1("t2_clr_alt", sticky_a, 1'b0);
    @(posedge clock);
    #1;

    // 3: rounding of +/- half LSB
    push(mk(32'h1, 32'hFFFFFFFF, 0), 32'h8000,
         mk(32'h0, 32'hFFFFFFFF, 0), mk(32'h1, 32'h0, 0), 1, 1);
    set_empty(1'b1);
    wait_drain();
    chk1("t3_sticky_main", sticky_m, 1'b0);

    // 4: eight back-to-back vectors with a 5-cycle downstream stall
    w0 = n_wr;
    p0 = pops;
    fork
      begin
        for (int k = 0; k < 8; k++)
          push(mk(32'h1000 + k, 32'h2000 + k, 32'h3000 + k), 32'h10000,
               mk(32'h1000 + k, 32'h2000 + k, 32'h3000 + k),
               mk(32'h1000 + k, 32'h2000 + k, 32'h3000 + k), 1, 0);
        set_empty(1'b1);
      end
      begin
        for (int i = 0; i < 200 && pops < p0 + 4; i++) @(posedge clock);
        #1 set_full(1'b1);
        for (int i = 0; i < 5; i++) begin
          @(negedge clock);
          chk1("t4_blocked_rd_en", m_if.in_rd_en, 1'b0);
          chk1("t4_blocked_wr_en", m_if.out_wr_en, 1'b0);
        end
        @(posedge clock);
        #1 set_full(1'b0);
      end
    join
    wait_drain();
    chk("t4_writes", DW'(n_wr - w0), 32'd8);

    // 5: clear and overflow write in the same cycle -> set wins
    ovf_clr = 1'b1;
    push(mk(32'h7FFF0000, 0, 0), 32'h20000,
         mk(32'h7FFFFFFF, 0, 0), mk(32'hFFFE0000, 0, 0), 1, 1);
    set_empty(1'b1);
    @(posedge clock);
    @(posedge clock);
    #1 ovf_clr = 1'b0;
    @(negedge clock);
    chk1("t5_sticky_main", sticky_m, 1'b1);
    chk1("t5_sticky_alt", sticky_a, 1'b1);
    wait_drain();

    // 6: reset with two vectors in flight
    w0 = n_wr;
    push(mk(32'h5, 32'h6, 32'h7), 32'h10000, mk(0, 0, 0), mk(0, 0, 0), 0, 0);
    push(mk(32'h8, 32'h9, 32'hA), 32'h10000, mk(0, 0, 0), mk(0, 0, 0), 0, 0);
    reset_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk1("t6_rst_wr_en", m_if.out_wr_en, 1'b0);
      chk1("t6_rst_rd_en", m_if.in_rd_en, 1'b0);
    end
    chk1("t6_rst_sticky", sticky_m, 1'b0);
    set_empty(1'b1);
    @(posedge clock);
    #1 reset_n = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    chk("t6_no_write", DW'(n_wr - w0), 32'd0);
    push(mk(32'h10000, 32'hFFFF0000, 32'h28000), 32'h20000,
         mk(32'h20000, 32'hFFFE0000, 32'h50000),
         mk(32'h20000, 32'hFFFE0000, 32'h50000), 1, 1);
    set_empty(1'b1);
    wait_drain();
    chk("t6_after_write", DW'(n_wr - w0), 32'd1);

    chk("sb_empty", DW'(sb.size()), 32'd0);
    chk("total_writes", DW'(n_wr), DW'(n_push));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
